// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: 16-bit SPI responder that returns 12-bit channel readings chosen by the previous command frame
module a2d_spi_resp #(
  parameter int SCLK_MIN_CLKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] chnl_data,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;
  if (SCLK_MIN_CLKS < 8) begin : g_chk
    $error("SCLK_MIN_CLKS below 8 is unsupported");
  end
  state_t      state;
  logic [2:0]  ss_q, sclk_q;
  logic [1:0]  mosi_q;
  logic [15:0] tx_shft, rx_shft, rx_nx;
  logic [4:0]  bit_cnt, cnt_nx;
  logic [2:0]  prev_ch;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, take;
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  // the SCLK rise is folded in before an SS_n rise on the same clk, so a late 16th bit still counts
  assign take   = sclk_rise && state != IDLE && bit_cnt < 5'd16;
  assign rx_nx  = take ? {rx_shft[14:0], mosi_q[1]} : rx_shft;
  assign cnt_nx = take ? bit_cnt + 5'd1 : bit_cnt;
  assign MISO   = ~ss_q[1] & tx_shft[15];
  assign busy   = state != IDLE;
  // SS_n synchronizer resets low so a select still held after reset does not look like a new fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ss_q   <= 3'b000;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      tx_shft   <= '0;
      rx_shft   <= '0;
      bit_cnt   <= '0;
      prev_ch   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        if (ss_fall) begin
          tx_shft <= {4'h0, chnl_data[12*prev_ch +: 12]};
          rx_shft <= '0;
          bit_cnt <= '0;
          state   <= ARMED;
        end
      end else begin
        rx_shft <= rx_nx;
        bit_cnt <= cnt_nx;
        if (sclk_rise) state <= SHIFT;
        if (state == SHIFT && sclk_fall) tx_shft <= {tx_shft[14:0], 1'b0};
        if (ss_rise) begin
          state <= IDLE;
          if (cnt_nx == 5'd16) begin
            cmd     <= rx_nx;
            prev_ch <= rx_nx[13:11];
            cmd_rdy <= 1'b1;
          end else frame_err <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed and randomized frames against a channel-pipelined reference model
module tb_a2d_spi_resp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] chnl_data = '0;
  logic [15:0] cmd;
  logic        cmd_rdy, frame_err, busy;
  int          n_chk = 0, n_err = 0, n_rdy = 0, n_ferr = 0, m_rdy = 0, m_ferr = 0;
  logic [2:0]  m_prev = 3'd0;
  logic [15:0] m_cmd = 16'h0000;
  logic [15:0] got;

  a2d_spi_resp #(.SCLK_MIN_CLKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .chnl_data(chnl_data), .cmd(cmd), .cmd_rdy(cmd_rdy), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_rdy) n_rdy++;
    if (frame_err) n_ferr++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ch_val(input logic [95:0] d, input logic [2:0] n);
    logic [11:0] v [8];
    for (int k = 0; k < 8; k++) v[k] = d[12*k +: 12];
    return v[n];
  endfunction

  // One master frame: nbits SCLK pulses, optional SS_n rise coinciding with the last SCLK rise
  task automatic frame(input logic [15:0] w, input int nbits, input bit same, input bit raise,
                       output logic [15:0] word);
    logic [15:0] exp;
    word = '0;
    exp  = {4'h0, ch_val(chnl_data, m_prev)};
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      repeat (8) @(negedge clk);
      word = {word[14:0], MISO};
      if (i == 8) chk("busy_mid", busy, 1);
      SCLK = 1'b1;
      if (same && i == nbits - 1) SS_n = 1'b1;
      else repeat (8) @(negedge clk);
    end
    if (nbits == 16) chk("miso_word", word, exp);
    if (raise) begin
      SS_n = 1'b1;
      if (nbits == 16) begin
        m_prev = w[13:11];
        m_cmd  = w;
        m_rdy++;
      end else m_ferr++;
      repeat (2) @(negedge clk);
      chk("rdy_early", cmd_rdy, 0);
      chk("ferr_early", frame_err, 0);
      @(negedge clk);
      chk("cmd_rdy", cmd_rdy, nbits == 16);
      chk("frame_err", frame_err, nbits != 16);
      chk("cmd", cmd, m_cmd);
      chk("busy_end", busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    chnl_data = {$urandom, $urandom, $urandom};
    chnl_data[11:0] = 12'hABC;
    repeat (3) @(negedge clk);
    chk("rst_miso", MISO, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame(16'h2000, 16, 0, 1, got);
    chk("first_frame", got, 16'h0ABC);
    chnl_data[59:48] = 12'h123;
    frame(16'h2000, 16, 0, 1, got);
    chk("ch4_frame", got, 16'h0123);
    chk("rdy_count2", n_rdy, 2);
    chnl_data[11:0]  = 12'h111;
    chnl_data[59:48] = 12'h444;
    chnl_data[71:60] = 12'h555;
    frame(16'h0000, 16, 0, 1, got);
    frame(16'h0000, 16, 0, 1, got);
    chk("rot_ch0", got, 16'h0111);
    frame(16'h2000, 16, 0, 1, got);
    frame(16'h2000, 16, 0, 1, got);
    chk("rot_ch4", got, 16'h0444);
    frame(16'h2800, 16, 0, 1, got);
    frame(16'h2800, 16, 0, 1, got);
    chk("rot_ch5", got, 16'h0555);
    frame(16'h0000, 9, 0, 1, got);
    chk("short_ferr_count", n_ferr, 1);
    frame(16'h0000, 16, 0, 1, got);
    chk("short_old_ch", got, 16'h0555);
    frame(16'h0000, 16, 0, 1, got);
    chnl_data[11:0] = 12'h0F0;
    fork
      frame(16'h0000, 16, 0, 1, got);
      begin
        repeat (60) @(negedge clk);
        chnl_data[11:0] = 12'h00F;
      end
    join
    chk("snapshot", got, 16'h00F0);
    chnl_data[35:24] = 12'h9A5;
    frame(16'h1000, 16, 1, 1, got);
    frame(16'hC7FF & 16'hC7FF, 16, 1, 1, got);
    chk("same_clk_ch2", got, 16'h09A5);
    frame(16'h3800, 7, 0, 0, got);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd", cmd, 16'h0000);
    m_prev = 3'd0;
    m_cmd  = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_rdy", n_rdy, m_rdy);
    chk("rst_mid_ferr", n_ferr, m_ferr);
    chk("rst_mid_busy2", busy, 0);
    chnl_data[11:0] = 12'h7E1;
    frame(16'h2800, 16, 0, 1, got);
    chk("after_rst_ch0", got, 16'h07E1);
    for (int r = 0; r < 20; r++) begin
      chnl_data = {$urandom, $urandom, $urandom};
      frame(16'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16,
            1'($urandom_range(0, 1)), 1, got);
    end
    chk("rdy_total", n_rdy, m_rdy);
    chk("ferr_total", n_ferr, m_ferr);
    chk("idle_miso", MISO, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
